// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: 32-bit binary-angle arctangent table, quadrant
// angles and the FSM state type used by the vectoring engine.
package cordic_pkg;

  localparam int ANGLE_W = 32;

  localparam logic [ANGLE_W-1:0] ANGLE_90  = 32'h4000_0000;
  localparam logic [ANGLE_W-1:0] ANGLE_270 = 32'hC000_0000;

  // Aggregate gain of 16 micro-rotations in Q15 (1.64676 * 2^15).
  localparam int CORDIC_GAIN_Q15 = 53961;

  // atan(2^-i) scaled so that 2^32 is one full turn; entry 0 is the LSB slot.
  localparam logic [15:0][ANGLE_W-1:0] ATAN_TABLE = {
    32'h0000_517D, 32'h0000_A2FA, 32'h0001_45F3, 32'h0002_8BE6,
    32'h0005_17CC, 32'h000A_2F98, 32'h0014_5F2F, 32'h0028_BE53,
    32'h0051_7C55, 32'h00A2_F61E, 32'h0145_D7E1, 32'h028B_0D43,
    32'h0511_11D4, 32'h09FB_385B, 32'h12E4_051D, 32'h2000_0000
  };

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    DONE
  } cordic_state_t;

endpackage

// File: rtl/cordic_vectoring_if.sv
// Sample-in / result-out handshake bundle for the vectoring CORDIC.
interface cordic_vectoring_if #(
  parameter int WIDTH = 16
);
  import cordic_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x_in;
  logic [WIDTH-1:0]     y_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH+1:0]     magnitude;
  logic [ANGLE_W-1:0]   phase;

  // master: sample producer / result consumer; slave: the CORDIC engine.
  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, magnitude, phase
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, magnitude, phase
  );

endinterface

// File: rtl/cordic_micro_rotate.sv
// One combinational CORDIC micro-rotation: drives y toward zero by a step of
// atan(2^-i) and accumulates the applied angle in z.
module cordic_micro_rotate
  import cordic_pkg::*;
#(
  parameter int W = 18
) (
  input  logic signed [W-1:0]       x_i,
  input  logic signed [W-1:0]       y_i,
  input  logic        [ANGLE_W-1:0] z_i,
  input  logic        [3:0]         shift_i,
  input  logic                      y_neg_i,
  output logic signed [W-1:0]       x_o,
  output logic signed [W-1:0]       y_o,
  output logic        [ANGLE_W-1:0] z_o
);

  logic signed [W-1:0]       x_sh;
  logic signed [W-1:0]       y_sh;
  logic        [ANGLE_W-1:0] atan_i;

  assign x_sh   = x_i >>> shift_i;
  assign y_sh   = y_i >>> shift_i;
  assign atan_i = ATAN_TABLE[shift_i];

  always_comb begin
    if (y_neg_i) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring CORDIC: (I,Q) -> (K*|v|, atan2) with one micro-rotation
// per clock and valid/ready handshakes on both sides.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 16   // 1..16, bounded by the atan table length
) (
  input  logic               clock,
  input  logic               reset,
  cordic_vectoring_if.slave  bus
);

  localparam int W = WIDTH + 2;
  localparam logic [3:0] LAST_I = 4'(ITER - 1);

  cordic_state_t       state_q, state_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d;
  logic [ANGLE_W-1:0]  z_q, z_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                zero_q, zero_d;
  logic [W-1:0]        mag_q, mag_d;
  logic [ANGLE_W-1:0]  phase_q, phase_d;

  logic signed [W-1:0] x_ext, y_ext;
  logic signed [W-1:0] x_nx, y_nx;
  logic [ANGLE_W-1:0]  z_nx;

  assign x_ext = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
  assign y_ext = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};

  cordic_micro_rotate #(.W(W)) u_rot (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (cnt_q),
    .y_neg_i (y_q[W-1]),
    .x_o     (x_nx),
    .y_o     (y_nx),
    .z_o     (z_nx)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Fold left half-plane inputs into the right half-plane by +/-90 deg
          // so the micro-rotations only need to cover +/-99.9 deg.
          if (!x_ext[W-1]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!y_ext[W-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = ANGLE_90;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = ANGLE_270;
          end
          zero_d  = (bus.x_in == '0) && (bus.y_in == '0);
          cnt_d   = '0;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        x_d   = x_nx;
        y_d   = y_nx;
        z_d   = z_nx;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_I) begin
          mag_d   = zero_q ? '0 : W'(x_nx);
          phase_d = zero_q ? '0 : z_nx;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.magnitude = mag_q;
  assign bus.phase     = phase_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring (WIDTH=16, ITER=16): latency, quadrant
// coverage, zero/extreme inputs, backpressure and mid-operation reset.
module tb_cordic_vectoring;

  localparam int WIDTH   = 16;
  localparam int ITER    = 16;
  localparam int PH_TOL  = 1 << 17;
  localparam int MAG_TOL = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;

  logic [WIDTH+1:0] held_mag;
  logic [31:0]      held_ph;

  cordic_vectoring_if #(.WIDTH(WIDTH)) bus ();

  cordic_vectoring #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Modular distance, so angles straddling the +/-180 deg wrap compare correctly.
  task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                            input int tol);
    logic signed [31:0] d;
    logic ok;
    d  = $signed(obs - exp);
    if (d < 0) d = -d;
    ok = (d <= tol);
    n_checks++;
    assert (ok === 1'b1) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h tol=%0d", tag, obs, exp, tol);
  endtask

  // Present one sample, then count edges until out_valid (bounded at 40).
  task automatic run_sample(input logic [15:0] x, input logic [15:0] y, output int cycles);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    bus.y_in     = y;
    tick();
    bus.in_valid = 1'b0;
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check_eq("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_magnitude", 32'(bus.magnitude), 32'd0);
    check_eq("rst_phase",     bus.phase,          32'd0);

    // 0 deg
    run_sample(16'sd16384, 16'sd0, lat);
    check_eq("t1_latency", 32'(lat), 32'd16);
    check_eq("t1_in_ready_busy", 32'(bus.in_ready), 32'd0);
    check_near("t1_mag",   32'(bus.magnitude), 32'd26981, MAG_TOL);
    check_near("t1_phase", bus.phase, 32'h0000_0000, PH_TOL);
    pop();

    // +90 deg
    run_sample(16'sd0, 16'sd16384, lat);
    check_eq("t2a_latency", 32'(lat), 32'd16);
    check_near("t2a_mag",   32'(bus.magnitude), 32'd26981, MAG_TOL);
    check_near("t2a_phase", bus.phase, 32'h4000_0000, PH_TOL);
    pop();

    // 180 deg
    run_sample(-16'sd16384, 16'sd0, lat);
    check_eq("t2b_latency", 32'(lat), 32'd16);
    check_near("t2b_mag",   32'(bus.magnitude), 32'd26981, MAG_TOL);
    check_near("t2b_phase", bus.phase, 32'h8000_0000, PH_TOL);
    pop();

    // -45 deg
    run_sample(16'sd10000, -16'sd10000, lat);
    check_eq("t3a_latency", 32'(lat), 32'd16);
    check_near("t3a_mag",   32'(bus.magnitude), 32'd23289, MAG_TOL);
    check_near("t3a_phase", bus.phase, 32'hE000_0000, PH_TOL);
    pop();

    // -135 deg
    run_sample(-16'sd10000, -16'sd10000, lat);
    check_eq("t3b_latency", 32'(lat), 32'd16);
    check_near("t3b_mag",   32'(bus.magnitude), 32'd23289, MAG_TOL);
    check_near("t3b_phase", bus.phase, 32'hA000_0000, PH_TOL);
    pop();

    // Origin: exact zeros
    run_sample(16'sd0, 16'sd0, lat);
    check_eq("t4a_latency", 32'(lat), 32'd16);
    check_eq("t4a_mag",     32'(bus.magnitude), 32'd0);
    check_eq("t4a_phase",   bus.phase, 32'd0);
    pop();

    // Most negative I, no overflow
    run_sample(16'h8000, 16'sd0, lat);
    check_eq("t4b_latency", 32'(lat), 32'd16);
    check_near("t4b_mag",   32'(bus.magnitude), 32'd53961, MAG_TOL);
    check_near("t4b_phase", bus.phase, 32'h8000_0000, PH_TOL);
    pop();

    // Backpressure: hold result 5 cycles with a competing input offered
    run_sample(16'sd0, 16'sd16384, lat);
    check_eq("t5_latency", 32'(lat), 32'd16);
    held_mag = bus.magnitude;
    held_ph  = bus.phase;
    check_near("t5_mag", 32'(held_mag), 32'd26981, MAG_TOL);
    bus.in_valid = 1'b1;
    bus.x_in     = 16'sd123;
    bus.y_in     = -16'sd456;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("t5_hold_valid",    32'(bus.out_valid), 32'd1);
      check_eq("t5_hold_in_ready", 32'(bus.in_ready),  32'd0);
      check_near("t5_hold_mag",    32'(bus.magnitude), 32'd26981, MAG_TOL);
      check_near("t5_hold_phase",  bus.phase, 32'h4000_0000, PH_TOL);
    end
    check_eq("t5_mag_stable",   32'(bus.magnitude), 32'(held_mag));
    check_eq("t5_phase_stable", bus.phase, held_ph);
    bus.in_valid = 1'b0;
    pop();
    check_eq("t5_pop_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t5_pop_in_ready",  32'(bus.in_ready),  32'd1);
    run_sample(16'sd10000, -16'sd10000, lat);
    check_eq("t5b_latency", 32'(lat), 32'd16);
    check_near("t5b_mag",   32'(bus.magnitude), 32'd23289, MAG_TOL);
    check_near("t5b_phase", bus.phase, 32'hE000_0000, PH_TOL);
    pop();

    // Reset during iteration 7 discards the operation
    bus.in_valid = 1'b1;
    bus.x_in     = 16'sd0;
    bus.y_in     = 16'sd16384;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("t6_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check_eq("t6_rst_mag",       32'(bus.magnitude), 32'd0);
    run_sample(16'sd16384, 16'sd0, lat);
    check_eq("t6_latency", 32'(lat), 32'd16);
    check_near("t6_mag",   32'(bus.magnitude), 32'd26981, MAG_TOL);
    check_near("t6_phase", bus.phase, 32'h0000_0000, PH_TOL);
    pop();
    check_eq("t6_final_in_ready", 32'(bus.in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
